uart_rx_framer: RTL and testbench

Frame controller downstream of the UART receiver. Consumes the receiver's one-cycle byte strobes, hunts for a sync byte, checks length and optional checksum, and stores payload in an internal FIFO with commit/rollback, so the consumer only ever sees complete, validated frames. Bad, truncated or overflowing frames are discarded and reported.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_frame_fifo.sv | 55 +++++
 rtl/uart_rx_framer.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_framer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive framer: error codes, FSM states,
// and the inter-byte timeout helper.
package uart_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_LEN  = 3'd1,
    ERR_CHK  = 3'd2,
    ERR_OVF  = 3'd3,
    ERR_TMO  = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK
  } state_e;

  function automatic longint to_cycles(
    input longint bits,
    input longint clk_hz,
    input longint baud
  );
    return (bits * clk_hz) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_frame_fifo.sv
// Payload FIFO with speculative write pointer: reads see only committed
// entries, and an uncommitted frame can be rolled back in one cycle.
module uart_rx_frame_fifo #(
  parameter int unsigned DEPTH = 32
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       wr_en,
  input  logic [8:0] wr_data,
  input  logic       commit,
  input  logic       rollback,
  input  logic       rd_en,
  output logic [8:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] cm_q, cm_d;
  logic [AW:0] rd_q, rd_d;
  logic [AW:0] wr_inc;

  assign wr_inc = wr_en ? wr_q + 1'b1 : wr_q;

  always_comb begin
    wr_d = rollback ? cm_q : wr_inc;
    cm_d = commit ? wr_inc : cm_q;
    rd_d = rd_en ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_q <= '0;
      cm_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      cm_q <= cm_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_q[AW-1:0]];
  assign empty   = (cm_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/uart_rx_framer.sv
// Sync/length/checksum framer over a commit/rollback payload FIFO.
// Checksum byte and CHK state exist only with UART_RX_FRAMER_CHECKSUM_EN.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE   = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned FIFO_DEPTH   = 32,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       rx_dv,
  input  logic [7:0] rx_q,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code
);

  localparam longint TO_CYC =
    to_cycles(longint'(TIMEOUT_BITS), longint'(CLOCK_RATE),
              longint'(BAUD_RATE));
  localparam int CW = $clog2(TO_CYC + 1);

  state_e        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  err_e          code_q, code_d;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
  logic [7:0]    acc_q, acc_d;
`endif

  logic       wr_en, commit, rollback;
  logic       full, empty;
  logic [8:0] rd_data;

  uart_rx_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .arst_n   (arst_n),
    .wr_en    (wr_en),
    .wr_data  ({rem_q == 8'd1, rx_q}),
    .commit   (commit),
    .rollback (rollback),
    .rd_en    (m_valid && m_ready),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty)
  );

  assign m_valid   = !empty;
  assign m_data    = m_valid ? rd_data[7:0] : 8'h00;
  assign m_last    = m_valid && rd_data[8];
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
    acc_d    = acc_q;
`endif
    cnt_d    = (state_q == HUNT || rx_dv) ? '0 : cnt_q + 1'b1;
    if (rx_dv) begin
      unique case (state_q)
        HUNT: begin
          if (rx_q == SYNC_BYTE) state_d = LEN;
        end
        LEN: begin
          if (rx_q == 8'd0 || rx_q > 8'(MAX_LEN)) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = HUNT;
          end else begin
            rem_d   = rx_q;
            state_d = PAYLOAD;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
            acc_d   = rx_q;
`endif
          end
        end
        PAYLOAD: begin
          if (full) begin
            err_d    = 1'b1;
            code_d   = ERR_OVF;
            rollback = 1'b1;
            state_d  = HUNT;
          end else begin
            wr_en = 1'b1;
            rem_d = rem_q - 8'd1;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
            acc_d = acc_q ^ rx_q;
            if (rem_q == 8'd1) state_d = CHK;
`else
            if (rem_q == 8'd1) begin
              commit  = 1'b1;
              ok_d    = 1'b1;
              code_d  = ERR_NONE;
              state_d = HUNT;
            end
`endif
          end
        end
        CHK: begin
`ifdef UART_RX_FRAMER_CHECKSUM_EN
          if (rx_q == acc_q) begin
            commit = 1'b1;
            ok_d   = 1'b1;
            code_d = ERR_NONE;
          end else begin
            rollback = 1'b1;
            err_d    = 1'b1;
            code_d   = ERR_CHK;
          end
`endif
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT && cnt_q == CW'(TO_CYC - 1)) begin
      // counter reaches the limit on this edge
      err_d    = 1'b1;
      code_d   = ERR_TMO;
      rollback = 1'b1;
      state_d  = HUNT;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= HUNT;
      rem_q   <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer; honours UART_RX_FRAMER_CHECKSUM_EN
// when choosing frame layout.
module tb_uart_rx_framer;

  localparam longint TO = (64'd20 * 64'd100_000_000) / 64'd115_200;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_q = 8'h00;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       frame_ok;
  logic       frame_err;
  logic [2:0] err_code;

  int n_checks = 0;
  int n_errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int ok0, err0;
  logic [8:0] exp_q[$];

  uart_rx_framer dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rx_dv     (rx_dv),
    .rx_q      (rx_q),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious", {23'd0, m_last, m_data}, 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e[7:0]));
          check("m_last", 32'(m_last), 32'(e[8]));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_q  = b;
    rx_dv = 1'b1;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] seed,
                            input logic [7:0] step, input bit good);
    logic [7:0] acc, b;
    logic [7:0] len;
    len = 8'(n);
    acc = len;
    send_byte(8'hA5);
    idle(1);
    send_byte(len);
    idle(1);
    for (int i = 0; i < n; i++) begin
      b = seed + 8'(i) * step;
      acc = acc ^ b;
      if (good) exp_q.push_back({i == n - 1, b});
      send_byte(b);
`ifdef UART_RX_FRAMER_CHECKSUM_EN
      idle(1);
    end
    send_byte(acc);
`else
      if (i != n - 1) idle(1);
    end
`endif
    if (good) begin
      check("ok_pulse", 32'(frame_ok), 1);
      check("valid_n1", 32'(m_valid), 1);
    end
    idle(2);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    idle(3);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_ok", 32'(frame_ok), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_code", 32'(err_code), 0);
    arst_n = 1'b1;
    idle(2);

    // basic good frame
    m_ready = 1'b1;
    ok0 = ok_cnt;
    send_frame(3, 8'h11, 8'h11, 1'b1);
    wait_drain();
    check("ok_once", 32'(ok_cnt - ok0), 1);
    check("code_ok", 32'(err_code), 0);

`ifdef UART_RX_FRAMER_CHECKSUM_EN
    err0 = err_cnt;
    send_byte(8'hA5); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'hAA); idle(1);
    send_byte(8'hBB); idle(1);
    send_byte(8'h00); idle(3);
    check("chk_err", 32'(err_cnt - err0), 1);
    check("chk_code", 32'(err_code), 2);
    check("chk_noval", 32'(m_valid), 0);
`endif

    // bad lengths
    err0 = err_cnt;
    send_byte(8'hA5); idle(1);
    send_byte(8'h00); idle(1);
    send_byte(8'hA5); idle(1);
    send_byte(8'h11); idle(3);
    check("len_errs", 32'(err_cnt - err0), 2);
    check("len_code", 32'(err_code), 1);
    check("len_noval", 32'(m_valid), 0);

    // overflow
    m_ready = 1'b0;
    ok0 = ok_cnt;
    err0 = err_cnt;
    send_frame(16, 8'h20, 8'h01, 1'b1);
    send_frame(16, 8'h40, 8'h01, 1'b1);
    send_frame(16, 8'h01, 8'h01, 1'b0);
    check("ovf_ok", 32'(ok_cnt - ok0), 2);
    check("ovf_err", 32'(err_cnt - err0), 1);
    check("ovf_code", 32'(err_code), 3);
    check("ovf_sb", 32'(exp_q.size()), 32);
    m_ready = 1'b1;
    wait_drain();

    // timeout
    err0 = err_cnt;
    send_byte(8'hA5); idle(1);
    send_byte(8'h04); idle(1);
    send_byte(8'h01);
    idle(int'(TO) + 20);
    check("tmo_err", 32'(err_cnt - err0), 1);
    check("tmo_code", 32'(err_code), 4);
    ok0 = ok_cnt;
    send_frame(2, 8'h55, 8'h11, 1'b1);
    wait_drain();
    check("tmo_next_ok", 32'(ok_cnt - ok0), 1);
    check("tmo_next_code", 32'(err_code), 0);

    // reset mid-frame drops committed and pending data
    send_byte(8'hA5); idle(1);
    send_byte(8'h00); idle(2);
    m_ready = 1'b0;
    send_frame(3, 8'h61, 8'h02, 1'b1);
    send_byte(8'hA5); idle(1);
    send_byte(8'h04); idle(1);
    send_byte(8'h01); idle(1);
    check("pre_rst_valid", 32'(m_valid), 1);
    arst_n = 1'b0;
    #1;
    check("mr_valid", 32'(m_valid), 0);
    check("mr_last", 32'(m_last), 0);
    check("mr_data", 32'(m_data), 0);
    check("mr_ok", 32'(frame_ok), 0);
    check("mr_err", 32'(frame_err), 0);
    check("mr_code", 32'(err_code), 0);
    exp_q.delete();
    idle(2);
    arst_n = 1'b1;
    idle(1);
    m_ready = 1'b1;
    ok0 = ok_cnt;
    send_frame(4, 8'h70, 8'h03, 1'b1);
    wait_drain();
    check("mr_next_ok", 32'(ok_cnt - ok0), 1);

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
